// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/response codes, frame builder.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StShift,
        StAck,
        StWaitIdle
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_RSP_BAT_OK   = 8'hAA;

    // Host-to-device frame after the start bit: {stop, odd parity, data}, sent LSB first.
    function automatic logic [9:0] ps2_tx_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchronizer, glitch filter on the synced level, falling-edge pulse.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk100,
    input  logic rst,
    input  logic line_in,
    output logic line_sync,
    output logic line_filt,
    output logic line_fall
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync_meta;
    logic [CW-1:0] stable_cnt;

    // Two-flop synchronizer; resets high to match a released, pulled-up line.
    always_ff @(posedge clk100) begin
        if (rst) begin
            sync_meta <= 1'b1;
            line_sync <= 1'b1;
        end else begin
            sync_meta <= line_in;
            line_sync <= sync_meta;
        end
    end

    // Accept a new level only after FILTER_LEN consecutive samples that differ from the current one.
    always_ff @(posedge clk100) begin
        if (rst) begin
            line_filt  <= 1'b1;
            line_fall  <= 1'b0;
            stable_cnt <= '0;
        end else begin
            line_fall <= 1'b0;
            if (line_sync == line_filt) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                line_filt  <= line_sync;
                line_fall  <= ~line_sync;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, start bit, 8 data + parity + stop on device
// clock falls, then line-ACK check. Drives the open-drain pads through oe only.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 10_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk100,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e state;
    logic [9:0]    frame;
    logic [3:0]    bit_idx;
    logic [IW-1:0] inhibit_cnt;
    logic [TW-1:0] timeout_cnt;

    logic clk_sync, clk_filt, clk_fall;
    logic data_meta, data_sync;
    logic in_frame, timeout_hit;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk100    (clk100),
        .rst       (rst),
        .line_in   (ps2_clk_in),
        .line_sync (clk_sync),
        .line_filt (clk_filt),
        .line_fall (clk_fall)
    );

    // Data line only needs synchronizing; it is sampled on filtered clock falls.
    always_ff @(posedge clk100) begin
        if (rst) begin
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    // Timeout guards only the device-clocked phases; a fall on the terminal count wins.
    always_comb begin
        in_frame    = (state == StShift) || (state == StAck) || (state == StWaitIdle);
        timeout_hit = in_frame && !clk_fall && (timeout_cnt == TO_LAST);
    end

    // Transmit FSM with registered outputs.
    always_ff @(posedge clk100) begin
        if (rst) begin
            state       <= StIdle;
            frame       <= '0;
            bit_idx     <= '0;
            inhibit_cnt <= '0;
            timeout_cnt <= '0;
            tx_ready    <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (timeout_hit) begin
                state       <= StIdle;
                tx_ready    <= 1'b1;
                busy        <= 1'b0;
                tx_error    <= 1'b1;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
            end else begin
                if (in_frame) begin
                    timeout_cnt <= clk_fall ? '0 : timeout_cnt + 1'b1;
                end
                unique case (state)
                    StIdle: begin
                        if (tx_valid && tx_ready) begin
                            frame       <= ps2_tx_frame(tx_data);
                            inhibit_cnt <= '0;
                            tx_ready    <= 1'b0;
                            busy        <= 1'b1;
                            ps2_clk_oe  <= 1'b1;
                            ps2_data_oe <= 1'b0;
                            state       <= StInhibit;
                        end else begin
                            tx_ready <= 1'b1;
                        end
                    end
                    StInhibit: begin
                        if (inhibit_cnt == INH_LAST) begin
                            ps2_data_oe <= 1'b1;
                            state       <= StReq;
                        end else begin
                            inhibit_cnt <= inhibit_cnt + 1'b1;
                        end
                    end
                    StReq: begin
                        // Release clock with data held low: device now clocks the frame in.
                        ps2_clk_oe  <= 1'b0;
                        bit_idx     <= '0;
                        timeout_cnt <= '0;
                        state       <= StShift;
                    end
                    StShift: begin
                        if (clk_fall) begin
                            ps2_data_oe <= ~frame[bit_idx];
                            bit_idx     <= bit_idx + 1'b1;
                            if (bit_idx == 4'd9) begin
                                state <= StAck;
                            end
                        end
                    end
                    StAck: begin
                        if (clk_fall) begin
                            if (!data_sync) begin
                                state <= StWaitIdle;
                            end else begin
                                state       <= StIdle;
                                tx_ready    <= 1'b1;
                                busy        <= 1'b0;
                                tx_error    <= 1'b1;
                                ps2_data_oe <= 1'b0;
                            end
                        end
                    end
                    StWaitIdle: begin
                        if (clk_sync && clk_filt && data_sync) begin
                            state    <= StIdle;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            tx_done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a simple PS/2 device model on open-drain pads.
`timescale 1ns/1ps
module tb_ps2_tx;
    import ps2_pkg::*;

    localparam int unsigned INHIBIT = 100;
    localparam int unsigned TIMEOUT = 2000;
    localparam int unsigned FILT    = 8;
    localparam int unsigned HALF    = 100;
    // Pad edge -> registered fall pulse (2 sync + FILT filter) plus one FSM edge to clear.
    localparam int unsigned FALL_LAT = 2 + FILT + 1;

    logic       clk100 = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe;

    logic bfm_clk_low = 1'b0;
    logic bfm_data_low = 1'b0;
    logic glitch_low = 1'b0;
    bit   frame_over = 1'b0;
    wire  ps2_clk_pad  = ~(ps2_clk_oe | bfm_clk_low | glitch_low);
    wire  ps2_data_pad = ~(ps2_data_oe | bfm_data_low);

    int tests_run = 0;
    int tests_failed = 0;
    int done_total = 0, err_total = 0, inh_total = 0, req_total = 0, start_total = 0;
    logic busy_prev = 1'b0;

    always #5 clk100 = ~clk100;

    ps2_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FILTER_LEN     (FILT)
    ) dut (
        .clk100      (clk100),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clk_in  (ps2_clk_pad),
        .ps2_data_in (ps2_data_pad),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    // Event monitor: pulse counts and line-phase cycle counts.
    always @(negedge clk100) begin
        if (tx_done) done_total <= done_total + 1;
        if (tx_error) err_total <= err_total + 1;
        if (ps2_clk_oe && !ps2_data_oe) inh_total <= inh_total + 1;
        if (ps2_clk_oe && ps2_data_oe) req_total <= req_total + 1;
        if (busy && !busy_prev) start_total <= start_total + 1;
        busy_prev <= busy;
    end

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk100);
        tx_valid = 1'b0;
    endtask

    // Device model: waits for host request, clocks 11 times, samples data on rising edges,
    // optionally drives ACK low on the 11th clock; stop_after=k holds clock low after fall k.
    task automatic bfm_frame(input int stop_after, input bit give_ack,
                             output logic [9:0] seen, output bit ok);
        int waited;
        seen = '0;
        ok = 1'b0;
        waited = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && waited < int'(INHIBIT) + 100) begin
            @(negedge clk100);
            waited++;
        end
        if (waited >= int'(INHIBIT) + 100) return;
        ok = 1'b1;
        repeat (HALF) @(negedge clk100);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && give_ack) begin
                bfm_data_low = 1'b1;
                repeat (20) @(negedge clk100);
            end
            bfm_clk_low = 1'b1;
            if (k == stop_after) return;
            repeat (HALF) @(negedge clk100);
            bfm_clk_low = 1'b0;
            if (k <= 10) seen[k-1] = ps2_data_pad;
            repeat (HALF) @(negedge clk100);
            bfm_data_low = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk100);
        tests_run++;
        if (tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_tx_ready: got %b expected 0", tx_ready);
        end
        tests_run++;
        if ({busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe});
        end
        rst = 1'b0;
        @(negedge clk100);
        tests_run++;
        if (tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b expected 1", tx_ready);
        end
    endtask

    task automatic test_set_leds();
        logic [9:0] seen;
        bit ok;
        int inh0, req0, done0, err0, n;
        inh0 = inh_total; req0 = req_total; done0 = done_total; err0 = err_total;
        send(PS2_CMD_SET_LEDS);
        tests_run++;
        if (busy !== 1'b1 || tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL accept_busy: got busy=%b ready=%b expected busy=1 ready=0", busy, tx_ready);
        end
        bfm_frame(0, 1'b1, seen, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL leds_request: got no host request expected one");
        end
        tests_run++;
        if (inh_total - inh0 !== int'(INHIBIT)) begin
            tests_failed++;
            $display("FAIL leds_inhibit_len: got %0d expected %0d", inh_total - inh0, INHIBIT);
        end
        tests_run++;
        if (req_total - req0 !== 1) begin
            tests_failed++;
            $display("FAIL leds_start_len: got %0d expected 1", req_total - req0);
        end
        tests_run++;
        if (seen !== 10'b11_1110_1101) begin
            tests_failed++;
            $display("FAIL leds_bits: got %b expected 1111101101", seen);
        end
        n = 0;
        while (done_total == done0 && err_total == err0 && n < 1000) begin
            @(negedge clk100);
            n++;
        end
        repeat (2) @(negedge clk100);
        tests_run++;
        if (done_total - done0 !== 1 || err_total - err0 !== 0) begin
            tests_failed++;
            $display("FAIL leds_result: got done=%0d err=%0d expected done=1 err=0",
                     done_total - done0, err_total - err0);
        end
        tests_run++;
        if ({busy, tx_ready, ps2_clk_oe, ps2_data_oe} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL leds_idle: got busy,ready,clk_oe,data_oe=%b expected 0100",
                     {busy, tx_ready, ps2_clk_oe, ps2_data_oe});
        end
        repeat (20) @(negedge clk100);
    endtask

    task automatic test_parity();
        logic [7:0] vec_data [2];
        logic [9:0] vec_exp [2];
        logic [9:0] seen;
        bit ok;
        int done0, n;
        vec_data[0] = 8'h00; vec_exp[0] = 10'b11_0000_0000;
        vec_data[1] = 8'h01; vec_exp[1] = 10'b10_0000_0001;
        for (int i = 0; i < 2; i++) begin
            done0 = done_total;
            send(vec_data[i]);
            bfm_frame(0, 1'b1, seen, ok);
            tests_run++;
            if (seen !== vec_exp[i]) begin
                tests_failed++;
                $display("FAIL parity_bits[%0d]: got %b expected %b", i, seen, vec_exp[i]);
            end
            n = 0;
            while (done_total == done0 && n < 1000) begin
                @(negedge clk100);
                n++;
            end
            repeat (2) @(negedge clk100);
            tests_run++;
            if (done_total - done0 !== 1) begin
                tests_failed++;
                $display("FAIL parity_done[%0d]: got %0d expected 1", i, done_total - done0);
            end
            repeat (20) @(negedge clk100);
        end
    endtask

    task automatic test_timeout();
        logic [9:0] seen;
        bit ok;
        int done0, err0, n;
        done0 = done_total; err0 = err_total;
        send(8'h5A);
        bfm_frame(4, 1'b1, seen, ok);
        n = 0;
        while (!tx_error && n < int'(TIMEOUT) + 100) begin
            @(negedge clk100);
            n++;
        end
        tests_run++;
        if (n !== int'(TIMEOUT + FALL_LAT)) begin
            tests_failed++;
            $display("FAIL timeout_latency: got %0d expected %0d", n, TIMEOUT + FALL_LAT);
        end
        tests_run++;
        if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL timeout_release: got clk_oe,data_oe,busy=%b expected 000",
                     {ps2_clk_oe, ps2_data_oe, busy});
        end
        bfm_clk_low = 1'b0;
        repeat (30) @(negedge clk100);
        tests_run++;
        if (done_total - done0 !== 0 || err_total - err0 !== 1) begin
            tests_failed++;
            $display("FAIL timeout_result: got done=%0d err=%0d expected done=0 err=1",
                     done_total - done0, err_total - err0);
        end
    endtask

    task automatic test_no_ack();
        logic [9:0] seen;
        bit ok;
        int done0, err0;
        done0 = done_total; err0 = err_total;
        send(PS2_CMD_ENABLE);
        bfm_frame(0, 1'b0, seen, ok);
        repeat (20) @(negedge clk100);
        tests_run++;
        if (seen !== 10'b10_1111_0100) begin
            tests_failed++;
            $display("FAIL noack_bits: got %b expected 1011110100", seen);
        end
        tests_run++;
        if (done_total - done0 !== 0 || err_total - err0 !== 1) begin
            tests_failed++;
            $display("FAIL noack_result: got done=%0d err=%0d expected done=0 err=1",
                     done_total - done0, err_total - err0);
        end
        tests_run++;
        if ({busy, tx_ready, ps2_clk_oe, ps2_data_oe} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL noack_idle: got busy,ready,clk_oe,data_oe=%b expected 0100",
                     {busy, tx_ready, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] seen;
        bit ok;
        int done0, err0, n;
        done0 = done_total; err0 = err_total;
        send(8'h33);
        bfm_frame(6, 1'b1, seen, ok);
        repeat (20) @(negedge clk100);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_busy_before: got %b expected 1", busy);
        end
        rst = 1'b1;
        @(negedge clk100);
        tests_run++;
        if ({ps2_clk_oe, ps2_data_oe, busy, tx_ready} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midrst_release: got clk_oe,data_oe,busy,ready=%b expected 0000",
                     {ps2_clk_oe, ps2_data_oe, busy, tx_ready});
        end
        rst = 1'b0;
        @(negedge clk100);
        tests_run++;
        if (tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_ready: got %b expected 1", tx_ready);
        end
        bfm_clk_low = 1'b0;
        repeat (50) @(negedge clk100);
        tests_run++;
        if (done_total - done0 !== 0 || err_total - err0 !== 0) begin
            tests_failed++;
            $display("FAIL midrst_no_pulse: got done=%0d err=%0d expected 0 0",
                     done_total - done0, err_total - err0);
        end
        done0 = done_total;
        send(PS2_CMD_RESET);
        bfm_frame(0, 1'b1, seen, ok);
        n = 0;
        while (done_total == done0 && n < 1000) begin
            @(negedge clk100);
            n++;
        end
        repeat (2) @(negedge clk100);
        tests_run++;
        if (seen !== 10'b11_1111_1111 || done_total - done0 !== 1) begin
            tests_failed++;
            $display("FAIL midrst_resend: got bits=%b done=%0d expected 1111111111 done=1",
                     seen, done_total - done0);
        end
        repeat (20) @(negedge clk100);
    endtask

    task automatic test_busy_glitch();
        logic [9:0] seen;
        bit ok;
        int done0, err0, start0, n;
        done0 = done_total; err0 = err_total; start0 = start_total;
        frame_over = 1'b0;
        send(8'h96);
        fork
            begin
                bfm_frame(0, 1'b1, seen, ok);
                frame_over = 1'b1;
            end
            begin
                while (!frame_over) begin
                    repeat (37) @(negedge clk100);
                    if (!frame_over && !bfm_clk_low) begin
                        glitch_low = 1'b1;
                        repeat (2) @(negedge clk100);
                        glitch_low = 1'b0;
                    end
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk100);
                    tx_data  = 8'hA5;
                    tx_valid = i[0];
                end
                tx_valid = 1'b0;
            end
        join
        n = 0;
        while (done_total == done0 && err_total == err0 && n < 1000) begin
            @(negedge clk100);
            n++;
        end
        repeat (300) @(negedge clk100);
        tests_run++;
        if (seen !== 10'b11_1001_0110) begin
            tests_failed++;
            $display("FAIL glitch_bits: got %b expected 1110010110", seen);
        end
        tests_run++;
        if (done_total - done0 !== 1 || err_total - err0 !== 0) begin
            tests_failed++;
            $display("FAIL glitch_result: got done=%0d err=%0d expected done=1 err=0",
                     done_total - done0, err_total - err0);
        end
        tests_run++;
        if (start_total - start0 !== 1 || ps2_clk_oe !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_extra_frame: got starts=%0d clk_oe=%b expected starts=1 clk_oe=0",
                     start_total - start0, ps2_clk_oe);
        end
    endtask

    initial begin
        test_reset();
        test_set_leds();
        test_parity();
        test_timeout();
        test_no_ack();
        test_reset_mid_frame();
        test_busy_glitch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
